spike_aer_packetizer: RTL



---
 rtl/spike_aer_packetizer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/spike_aer_packetizer.sv
// spike_aer_packetizer: tags arbitrated spikes with the scan-window timestamp, buffers them and
// emits AER packets (one timestamp header word, then up to MAX_BURST neuron-ID body words).
// Optional macro SPIKE_PKT_PARITY_EN: bit[OUT_W-2] of every word carries even parity over the
// whole word; when undefined that bit is always 0.
module spike_aer_packetizer #(
    parameter int unsigned NEURON_ID_W = 4,
    parameter int unsigned TS_W        = 12,
    parameter int unsigned BUF_DEPTH   = 16,
    parameter int unsigned MAX_BURST   = 8,
    parameter int unsigned OUT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   scan_start_en,
    input  logic                   spike_valid,
    input  logic [NEURON_ID_W-1:0] spike_id,
    output logic                   spike_ready,
    output logic                   pkt_valid,
    output logic [OUT_W-1:0]       pkt_data,
    output logic                   pkt_last,
    input  logic                   pkt_ready,
    output logic [TS_W-1:0]        window_ts
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(MAX_BURST) + 1;

    typedef enum logic [0:0] {StIdle, StBody} state_e;

    logic [TS_W-1:0]        ts_mem [BUF_DEPTH];
    logic [NEURON_ID_W-1:0] id_mem [BUF_DEPTH];

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q;
    logic [TS_W-1:0]  ts_q;
    state_e           state_q, state_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic             pkt_valid_q, pkt_valid_d;
    logic [OUT_W-1:0] pkt_data_q, pkt_data_d;
    logic             pkt_last_q, pkt_last_d;

    logic                   push, pop, out_free;
    logic [TS_W-1:0]        head_ts, next_ts;
    logic [NEURON_ID_W-1:0] head_id;

    // Fill bit[OUT_W-2] so the whole word has even parity (feature builds only).
    function automatic logic [OUT_W-1:0] add_parity(input logic [OUT_W-1:0] w);
        logic [OUT_W-1:0] r;
        r = w;
`ifdef SPIKE_PKT_PARITY_EN
        r[OUT_W-2] = ^w;
`endif
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] header_word(input logic [TS_W-1:0] ts);
        logic [OUT_W-1:0] w;
        w = '0;
        w[OUT_W-1] = 1'b1;
        w[TS_W-1:0] = ts;
        return add_parity(w);
    endfunction

    function automatic logic [OUT_W-1:0] body_word(input logic [NEURON_ID_W-1:0] id);
        logic [OUT_W-1:0] w;
        w = '0;
        w[NEURON_ID_W-1:0] = id;
        return add_parity(w);
    endfunction

    assign push     = spike_valid && ready_q;
    assign out_free = !pkt_valid_q || pkt_ready;
    assign head_ts  = ts_mem[rd_ptr_q];
    assign head_id  = id_mem[rd_ptr_q];
    assign next_ts  = ts_mem[rd_ptr_q + AW'(1)];

    // Spike buffer storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wr_ptr_q] <= ts_q;
            id_mem[wr_ptr_q] <= spike_id;
        end
    end

    // Occupancy next-state.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Packet FSM: header load in idle, body loads (with last decision) in body.
    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        pkt_valid_d = pkt_valid_q;
        pkt_data_d  = pkt_data_q;
        pkt_last_d  = pkt_last_q;
        pop         = 1'b0;
        if (out_free) begin
            pkt_valid_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (count_q != '0) begin
                        pkt_valid_d = 1'b1;
                        pkt_data_d  = header_word(head_ts);
                        pkt_last_d  = 1'b0;
                        burst_d     = '0;
                        state_d     = StBody;
                    end
                end
                StBody: begin
                    // Head stays buffered from header load, so it is always present here.
                    pkt_valid_d = 1'b1;
                    pkt_data_d  = body_word(head_id);
                    pop         = 1'b1;
                    burst_d     = burst_q + BW'(1);
                    pkt_last_d  = (burst_q == BW'(MAX_BURST - 1)) || (count_q < CW'(2)) ||
                                  (next_ts != head_ts);
                    if (pkt_last_d) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State, pointers, timestamp and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b1;
            ts_q        <= '0;
            state_q     <= StIdle;
            burst_q     <= '0;
            pkt_valid_q <= 1'b0;
            pkt_data_q  <= '0;
            pkt_last_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            // Registered full flag keeps pkt_ready off the spike_ready path.
            ready_q <= (count_d != CW'(BUF_DEPTH));
            if (scan_start_en) begin
                ts_q <= ts_q + TS_W'(1);
            end
            state_q     <= state_d;
            burst_q     <= burst_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_data_q  <= pkt_data_d;
            pkt_last_q  <= pkt_last_d;
        end
    end

    assign spike_ready = ready_q;
    assign window_ts   = ts_q;
    assign pkt_valid   = pkt_valid_q;
    assign pkt_data    = pkt_data_q;
    assign pkt_last    = pkt_last_q;

endmodule
